// File: rtl/memory_cycle.sv
// -----------------------------------------------------------------------------
// memory_cycle : MEM stage of the RISC-V pipeline.
//
// Takes the EX/MEM bundle, performs the load or store over a req/gnt/rvalid
// data-memory handshake and registers the MEM/WB bundle. StallM freezes the
// upstream stages while an access is outstanding, so the EX/MEM inputs stay
// stable for the whole access.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   ValidM              EX/MEM slot holds a real instruction (0 = bubble)
//   RegWriteM           instruction writes the register file
//   MemWriteM           store
//   ResultSrcM          load
//   RD_M, PCPlus4M      destination register, PC+4
//   WriteDataM          store data
//   ALU_ResultM         ALU result / memory address
//   dmem_req/we/addr/wdata   request side of the data-memory handshake
//   dmem_gnt            request accepted this cycle
//   dmem_rvalid/rdata   read response
//   StallM              combinational stall to upstream stages
//   RegWriteW .. ReadDataW   registered MEM/WB bundle
//   misalign_err        (MEM_MISALIGN_CHECK_EN only) misaligned access flag
//
// Build option
//   MEM_MISALIGN_CHECK_EN : when defined, a memory op whose address is not
//   word aligned is not sent to memory; it completes in one cycle with
//   RegWriteW forced to 0 and misalign_err raised for that WB cycle.
// -----------------------------------------------------------------------------
module memory_cycle #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ValidM,
   input  logic            RegWriteM,
   input  logic            MemWriteM,
   input  logic            ResultSrcM,
   input  logic [4:0]      RD_M,
   input  logic [XLEN-1:0] PCPlus4M,
   input  logic [XLEN-1:0] WriteDataM,
   input  logic [XLEN-1:0] ALU_ResultM,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            StallM,
   output logic            RegWriteW,
   output logic            ResultSrcW,
   output logic [4:0]      RD_W,
   output logic [XLEN-1:0] PCPlus4W,
   output logic [XLEN-1:0] ALU_ResultW,
   output logic [XLEN-1:0] ReadDataW
`ifdef MEM_MISALIGN_CHECK_EN
   ,
   output logic            misalign_err
`endif
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ    = 2'd1,
      S_WAIT_R = 2'd2
   } state_t;

   state_t          r_state;

   logic            r_reg_write;
   logic            r_result_src;
   logic [4:0]      r_rd;
   logic [XLEN-1:0] r_pc_plus4;
   logic [XLEN-1:0] r_alu_result;
   logic [XLEN-1:0] r_read_data;

   logic            w_is_mem;
   logic            w_misalign;
   logic            w_mem_op;
   logic            w_req;
   logic            w_stall;

   // A store is recognised whenever MemWriteM is set, even if ResultSrcM is
   // also (illegally) set.
   assign w_is_mem = ValidM & (MemWriteM | ResultSrcM);

`ifdef MEM_MISALIGN_CHECK_EN
   logic r_misalign;
   assign w_misalign = w_is_mem & (ALU_ResultM[1:0] != 2'b00);
`else
   assign w_misalign = 1'b0;
`endif

   assign w_mem_op = w_is_mem & ~w_misalign;

   // Request and stall are combinational so a store granted in its first
   // cycle completes without stalling.
   always_comb begin
      w_req   = 1'b0;
      w_stall = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_mem_op) begin
               w_req   = 1'b1;
               w_stall = ~(MemWriteM & dmem_gnt);
            end
         end
         S_REQ: begin
            w_req   = 1'b1;
            w_stall = ~(MemWriteM & dmem_gnt);
         end
         S_WAIT_R: begin
            w_stall = ~dmem_rvalid;
         end
         default: begin
            w_req   = 1'b0;
            w_stall = 1'b0;
         end
      endcase
   end

   assign dmem_req   = w_req;
   assign dmem_we    = w_req & MemWriteM;
   assign dmem_addr  = ALU_ResultM;
   assign dmem_wdata = WriteDataM;
   assign StallM     = w_stall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_mem_op) begin
                  if (!dmem_gnt)
                     r_state <= S_REQ;
                  else if (!MemWriteM)
                     r_state <= S_WAIT_R;
               end
            end
            S_REQ: begin
               if (dmem_gnt)
                  r_state <= MemWriteM ? S_IDLE : S_WAIT_R;
            end
            S_WAIT_R: begin
               if (dmem_rvalid)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // MEM/WB: stalled edges insert a bubble (write enables cleared, payload
   // held), the completion edge captures the frozen EX/MEM bundle. This gives
   // exactly one WB entry per instruction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_reg_write  <= 1'b0;
         r_result_src <= 1'b0;
         r_rd         <= '0;
         r_pc_plus4   <= '0;
         r_alu_result <= '0;
         r_read_data  <= '0;
      end else if (w_stall) begin
         r_reg_write  <= 1'b0;
         r_result_src <= 1'b0;
      end else begin
         r_reg_write  <= ValidM & RegWriteM & ~w_misalign;
         r_result_src <= ValidM & ResultSrcM;
         r_rd         <= RD_M;
         r_pc_plus4   <= PCPlus4M;
         r_alu_result <= ALU_ResultM;
         // Only a load finishing in WAIT_R carries memory data.
         r_read_data  <= (r_state == S_WAIT_R) ? dmem_rdata : '0;
      end
   end

`ifdef MEM_MISALIGN_CHECK_EN
   // A misaligned op never leaves IDLE, so the flag is tied to that state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_misalign <= 1'b0;
      else
         r_misalign <= ~w_stall & w_misalign & (r_state == S_IDLE);
   end
   assign misalign_err = r_misalign;
`endif

   assign RegWriteW   = r_reg_write;
   assign ResultSrcW  = r_result_src;
   assign RD_W        = r_rd;
   assign PCPlus4W    = r_pc_plus4;
   assign ALU_ResultW = r_alu_result;
   assign ReadDataW   = r_read_data;

endmodule

// File: tb/tb_memory_cycle.sv
module tb_memory_cycle;
   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic            ValidM, RegWriteM, MemWriteM, ResultSrcM;
   logic [4:0]      RD_M;
   logic [XLEN-1:0] PCPlus4M, WriteDataM, ALU_ResultM;
   logic            dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
   logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic            StallM, RegWriteW, ResultSrcW;
   logic [4:0]      RD_W;
   logic [XLEN-1:0] PCPlus4W, ALU_ResultW, ReadDataW;
`ifdef MEM_MISALIGN_CHECK_EN
   logic            misalign_err;
`endif

   memory_cycle #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
      .ResultSrcM(ResultSrcM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
      .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .StallM(StallM),
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
      .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW)
`ifdef MEM_MISALIGN_CHECK_EN
      , .misalign_err(misalign_err)
`endif
   );

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic        rw;
      logic        rs;
      logic [4:0]  rd;
      logic [31:0] pc4;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic        mis;
   } wb_t;

   wb_t exp_q[$];

   // Reference architectural memory (program order) and the responder's memory.
   logic [31:0] ref_mem  [logic [31:0]];
   logic [31:0] dmem_mem [logic [31:0]];

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Current slot presented to the DUT, used by the request monitor.
   logic        cur_req_ok = 1'b0;
   logic        cur_store = 1'b0;
   logic [31:0] cur_addr = '0;
   logic [31:0] cur_wdata = '0;

   function automatic logic is_mis(input logic v, input logic mw, input logic rs,
                                   input logic [31:0] a);
`ifdef MEM_MISALIGN_CHECK_EN
      return v & (mw | rs) & (a[1:0] != 2'b00);
`else
      return 1'b0 & v & mw & rs & a[0];
`endif
   endfunction

   task automatic set_inputs(input logic v, input logic rw, input logic mw, input logic rs,
                             input logic [4:0] rd, input logic [31:0] pc,
                             input logic [31:0] wd, input logic [31:0] alu);
      ValidM = v; RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs;
      RD_M = rd; PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = alu;
      cur_store  = mw;
      cur_addr   = alu;
      cur_wdata  = wd;
      cur_req_ok = v & (mw | rs) & ~is_mis(v, mw, rs, alu);
   endtask

   task automatic summary();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
   endtask

   // Present one instruction at posedge+1, record its expected WB entry and
   // hold it until the DUT stops stalling. Returns at posedge+1 after the
   // completion edge, with the number of stalled cycles.
   task automatic drive_slot(input logic v, input logic rw, input logic mw, input logic rs,
                             input logic [4:0] rd, input logic [31:0] pc,
                             input logic [31:0] wd, input logic [31:0] alu,
                             output int stalls);
      wb_t e;
      logic mis, is_load, is_store;
      set_inputs(v, rw, mw, rs, rd, pc, wd, alu);
      mis      = is_mis(v, mw, rs, alu);
      is_store = v & mw & ~mis;
      is_load  = v & rs & ~mw & ~mis;
      e.rw  = v & rw & ~mis;
      e.rs  = v & rs;
      e.rd  = rd;
      e.pc4 = pc;
      e.alu = alu;
      e.mis = mis;
      e.rdata = '0;
      if (is_load)
         e.rdata = ref_mem.exists(alu) ? ref_mem[alu] : init_word(alu);
      if (is_store)
         ref_mem[alu] = wd;
      exp_q.push_back(e);
      stalls = 0;
      forever begin
         @(negedge clk);
         if (!StallM) break;
         stalls++;
         if (stalls > 64) begin
            failures++;
            $display("FAIL stall_timeout actual=%0d required<=64", stalls);
            summary();
            $fatal(1, "stall bound expired");
         end
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- memory responder ----------------
   int          gnt_mode = 0;   // 0 random, 1 always, 2 after gdelay request cycles
   int          gdelay = 0;
   int          rv_fixed = 0;   // 0 = random 1..3
   logic        spur_en = 1'b0;
   logic        pending = 1'b0;
   int          pend_cnt = 0;
   logic [31:0] pend_data = '0;
   int          req_cnt = 0;

   always @(negedge clk) begin
      if (dmem_req && dmem_gnt) begin
         if (dmem_we) begin
            dmem_mem[dmem_addr] = dmem_wdata;
         end else begin
            pending   = 1'b1;
            pend_cnt  = (rv_fixed != 0) ? rv_fixed : int'($urandom_range(1, 3));
            pend_data = dmem_mem.exists(dmem_addr) ? dmem_mem[dmem_addr] : init_word(dmem_addr);
         end
         req_cnt = 0;
      end else if (dmem_req) begin
         req_cnt++;
      end else begin
         req_cnt = 0;
      end
   end

   always @(posedge clk) begin
      #2;
      case (gnt_mode)
         1:       dmem_gnt = 1'b1;
         2:       dmem_gnt = (req_cnt >= gdelay);
         default: dmem_gnt = ($urandom_range(0, 9) < 6);
      endcase
      if (pending) begin
         if (pend_cnt <= 1) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = pend_data;
            pending     = 1'b0;
         end else begin
            pend_cnt--;
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
         end
      end else begin
         dmem_rvalid = spur_en && ($urandom_range(0, 7) == 0);
         dmem_rdata  = $urandom;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic        mon_en = 1'b0;
   logic        armed = 1'b0;
   logic        stall_prev = 1'b0;
   logic [31:0] prev_alu = '0;

   always @(negedge clk) begin
      wb_t e;
      if (mon_en && armed) begin
         if (stall_prev) begin
            check("stall_bubble_regwrite", {31'b0, RegWriteW}, 32'd0);
            check("stall_bubble_resultsrc", {31'b0, ResultSrcW}, 32'd0);
            check("stall_hold_alu", ALU_ResultW, prev_alu);
         end else if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wb_underflow actual=entry required=none");
         end else begin
            e = exp_q.pop_front();
            check("wb_regwrite", {31'b0, RegWriteW}, {31'b0, e.rw});
            check("wb_resultsrc", {31'b0, ResultSrcW}, {31'b0, e.rs});
            check("wb_rd", {27'b0, RD_W}, {27'b0, e.rd});
            check("wb_pcplus4", PCPlus4W, e.pc4);
            check("wb_alu", ALU_ResultW, e.alu);
            check("wb_readdata", ReadDataW, e.rdata);
`ifdef MEM_MISALIGN_CHECK_EN
            check("wb_misalign", {31'b0, misalign_err}, {31'b0, e.mis});
`endif
         end
      end
      if (mon_en && dmem_req) begin
         check("req_allowed", {31'b0, cur_req_ok}, 32'd1);
         check("req_addr", dmem_addr, cur_addr);
         check("req_wdata", dmem_wdata, cur_wdata);
         check("req_we", {31'b0, dmem_we}, {31'b0, cur_store});
      end
      armed      = mon_en;
      stall_prev = StallM;
      prev_alu   = ALU_ResultW;
   end

   // ---------------- main stimulus ----------------
   initial begin
      int st, st2;
      logic v, rw, mw, rs;
      logic [31:0] a;
      int kind;

      set_inputs(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      #12;
      check("rst_regwrite", {31'b0, RegWriteW}, 32'd0);
      check("rst_resultsrc", {31'b0, ResultSrcW}, 32'd0);
      check("rst_rd", {27'b0, RD_W}, 32'd0);
      check("rst_pcplus4", PCPlus4W, 32'd0);
      check("rst_alu", ALU_ResultW, 32'd0);
      check("rst_readdata", ReadDataW, 32'd0);
      check("rst_req", {31'b0, dmem_req}, 32'd0);
      check("rst_stall", {31'b0, StallM}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      mon_en = 1'b1;

      // ALU passthrough
      gnt_mode = 1; rv_fixed = 1; spur_en = 1'b0;
      drive_slot(1, 1, 0, 0, 5'd5, 32'h0000_0404, 32'h0, 32'h0000_1234, st);
      check("alu_stalls", st, 0);
      check("alu_regwrite", {31'b0, RegWriteW}, 32'd1);
      check("alu_result", ALU_ResultW, 32'h0000_1234);

      // Store with same-cycle grant
      drive_slot(1, 0, 1, 0, 5'd0, 32'h0000_0408, 32'hDEAD_BEEF, 32'h0000_0100, st);
      check("store_stalls", st, 0);
      check("store_regwrite", {31'b0, RegWriteW}, 32'd0);
      drive_slot(1, 0, 1, 0, 5'd0, 32'h0000_040C, 32'hCAFE_F00D, 32'h0000_0104, st);

      // Load: grant after 2 cycles, rvalid 3 cycles after grant
      gnt_mode = 2; gdelay = 2; rv_fixed = 3;
      drive_slot(1, 1, 0, 1, 5'd7, 32'h0000_0410, 32'h0, 32'h0000_0104, st);
      check("load_stalls", st, 5);
      check("load_data", ReadDataW, 32'hCAFE_F00D);
      check("load_regwrite", {31'b0, RegWriteW}, 32'd1);
      gnt_mode = 1; rv_fixed = 1;
      drive_slot(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, st);
      check("load_once", {31'b0, RegWriteW}, 32'd0);

      // Load then store back to back
      drive_slot(1, 1, 0, 1, 5'd8, 32'h0000_0420, 32'h0, 32'h0000_0100, st);
      drive_slot(1, 0, 1, 0, 5'd0, 32'h0000_0424, 32'h1357_9BDF, 32'h0000_0108, st2);
      check("b2b_total_stalls", st + st2, 1);

      // Randomised traffic
      gnt_mode = 0; rv_fixed = 0; spur_en = 1'b1;
      for (int i = 0; i < 400; i++) begin
         v    = ($urandom_range(0, 9) < 8);
         kind = int'($urandom_range(0, 19));
         mw   = (kind >= 14);
         rs   = (kind >= 8 && kind <= 13) || kind == 19;
         rw   = (kind < 14) ? $urandom_range(0, 3) != 0 : 1'b0;
         a    = 32'h100 + ($urandom_range(0, 15) * 4);
         if ($urandom_range(0, 9) == 0) a = a + $urandom_range(1, 3);
         drive_slot(v, rw, mw, rs, 5'($urandom), $urandom, $urandom, a, st);
      end

      // Reset while waiting for read data; the late rvalid must be ignored
      gnt_mode = 1; rv_fixed = 6; spur_en = 1'b0;
      set_inputs(1, 1, 0, 1, 5'd9, 32'h0000_0500, 32'h0, 32'h0000_0108);
      @(negedge clk);
      @(posedge clk); #3;
      mon_en = 1'b0;
      rst = 1'b0;
      set_inputs(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
      #1;
      check("midrst_regwrite", {31'b0, RegWriteW}, 32'd0);
      check("midrst_rd", {27'b0, RD_W}, 32'd0);
      check("midrst_pcplus4", PCPlus4W, 32'd0);
      check("midrst_alu", ALU_ResultW, 32'd0);
      check("midrst_readdata", ReadDataW, 32'd0);
      check("midrst_req", {31'b0, dmem_req}, 32'd0);
      check("midrst_stall", {31'b0, StallM}, 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      mon_en = 1'b1;
      for (int i = 0; i < 8; i++)
         drive_slot(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, st);
      check("stale_rvalid_regwrite", {31'b0, RegWriteW}, 32'd0);
      rv_fixed = 2;
      drive_slot(1, 1, 0, 1, 5'd10, 32'h0000_0600, 32'h0, 32'h0000_0108, st);
      check("post_rst_load_stalls", st, 2);

`ifdef MEM_MISALIGN_CHECK_EN
      drive_slot(1, 1, 0, 1, 5'd11, 32'h0000_0700, 32'h0, 32'h0000_0102, st);
      check("mis_stalls", st, 0);
      check("mis_err", {31'b0, misalign_err}, 32'd1);
      check("mis_regwrite", {31'b0, RegWriteW}, 32'd0);
      drive_slot(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, st);
      check("mis_err_clear", {31'b0, misalign_err}, 32'd0);
`endif

      drive_slot(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, st);
      @(negedge clk); #1;
      check("queue_drained", exp_q.size(), 32'd0);
      summary();
      $finish;
   end

endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
- Pipeline MEM stage of the RISC-V core.
- Consumes the EX/MEM bundle driven by the execute stage (RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM).
- Performs the load or store over a req/gnt/rvalid data-memory handshake and registers the MEM/WB bundle.
- Raises StallM to freeze upstream stages while a memory access is outstanding.

Parameters:
XLEN, 32, data and address width; only 32 is supported.

Ports:
clk  in  1  core clock; all state on posedge.
rst  in  1  asynchronous, active-low reset (rst==0 resets).
ValidM  in  1  EX/MEM slot holds a real instruction; 0 = bubble.
RegWriteM  in  1  instruction writes the register file.
MemWriteM  in  1  store.
ResultSrcM  in  1  load (writeback selects memory data).
RD_M  in  5  destination register.
PCPlus4M  in  XLEN  PC+4 of the instruction.
WriteDataM  in  XLEN  store data.
ALU_ResultM  in  XLEN  ALU result, used as the memory address.
dmem_req  out  1  memory request.
dmem_we  out  1  1 = write, 0 = read; valid while dmem_req=1.
dmem_addr  out  XLEN  word address, equal to ALU_ResultM.
dmem_wdata  out  XLEN  equal to WriteDataM.
dmem_gnt  in  1  request accepted this cycle.
dmem_rvalid  in  1  read data valid; earliest one cycle after gnt.
dmem_rdata  in  XLEN  read data.
StallM  out  1  combinational; 1 = hold PC, IF/ID, ID/EX and EX/MEM.
RegWriteW  out  1  registered MEM/WB.
ResultSrcW  out  1  registered MEM/WB.
RD_W  out  5  registered MEM/WB.
PCPlus4W  out  XLEN  registered MEM/WB.
ALU_ResultW  out  XLEN  registered MEM/WB.
ReadDataW  out  XLEN  registered MEM/WB; load data.

Behaviour:
- Memory op: mem_op = ValidM & (MemWriteM | ResultSrcM). MemWriteM and ResultSrcM both 1 is illegal; MemWriteM has priority and the op is treated as a store.
- Non-memory op or bubble: StallM=0; MEM/WB registers capture the inputs on the next edge (1-cycle latency); ReadDataW <= 0.

FSM states: IDLE, REQ, WAIT_R.
- IDLE:
  - If mem_op: dmem_req=1, dmem_we=MemWriteM.
  - Store with gnt=1: completes, StallM=0, stay IDLE.
  - Load with gnt=1: StallM=1, go WAIT_R.
  - gnt=0: StallM=1, go REQ.
- REQ:
  - dmem_req=1; dmem_addr, dmem_we and dmem_wdata held stable (inputs are frozen by StallM).
  - Store with gnt: complete, StallM=0, go IDLE.
  - Load with gnt: StallM=1, go WAIT_R.
  - No gnt: remain, StallM=1.
- WAIT_R:
  - dmem_req=0.
  - rvalid=0: StallM=1.
  - rvalid=1: StallM=0, ReadDataW <= dmem_rdata, go IDLE.
- MEM/WB update:
  - Registers load the instruction on the completion edge (the cycle StallM=0).
  - On every edge where StallM=1, the registers load a bubble: RegWriteW=0, ResultSrcW=0; other fields hold.
  - Consequence: exactly one WB entry per instruction.
- Ignored handshake inputs: dmem_gnt outside IDLE/REQ with dmem_req=1, and dmem_rvalid outside WAIT_R, have no effect.
- Back-to-back memory ops: the next op may issue in the cycle after completion; no dead cycle is required.
- Reset (asynchronous, any state including mid-access):
  - FSM to IDLE; dmem_req=0.
  - All MEM/WB outputs 0.
  - A late rvalid after reset is ignored.
- Reset values: dmem_req=0 (combinational, from IDLE with ValidM=0 at reset). StallM follows combinational rules.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- When defined:
  - Adds output misalign_err (1 bit, registered, reset 0).
  - A mem_op with ALU_ResultM[1:0]!=0 issues no dmem_req and does not stall.
  - Completes in 1 cycle with RegWriteW forced 0; misalign_err=1 for that WB cycle.
- When undefined:
  - No port and no check.
  - Misaligned addresses are passed to dmem unchanged.

Test Plan:
1. ALU op passthrough: ValidM=1, RegWriteM=1, RD_M=5, ALU_ResultM=0x1234 -> next cycle RegWriteW=1, RD_W=5, ALU_ResultW=0x1234, StallM never 1.
2. Store, same-cycle gnt: addr 0x100, wdata 0xDEADBEEF, gnt=1 -> dmem_req=1 and dmem_we=1 for one cycle, StallM=0, RegWriteW=0 next cycle.
3. Load, gnt delayed 2 cycles, rvalid 3 cycles after gnt, rdata 0xCAFEF00D -> StallM=1 for 5 cycles, addr stable throughout, then ReadDataW=0xCAFEF00D, RegWriteW=1 exactly once.
4. Load then store back-to-back, both gnt immediate, rvalid at +1 -> one stall cycle total, two WB entries in order.
5. Reset asserted while in WAIT_R, rvalid pulsed after release -> FSM IDLE, all W outputs 0, no WB write from the stale rvalid.
6. With MEM_MISALIGN_CHECK_EN: load at 0x102 -> no dmem_req, misalign_err=1, RegWriteW=0 for one cycle.
